// File: rtl/cpen391_pio_pulse_out.sv
// rtl/cpen391_pio_pulse_out.sv - Avalon-MM output PIO with atomic set/clear and a timed pulse engine
//
// Ports:
//   clk, reset_n            : system clock, asynchronous active-low reset
//   address[2:0]            : word address
//   chipselect, write_n     : a write is chipselect & ~write_n, applied on the next clk edge
//   writedata[31:0]         : write data
//   readdata[31:0]          : combinational read data selected by address
//   out_port[WIDTH-1:0]     : data_out XOR (busy ? pulse mask : 0)
//   irq                     : pulse-done interrupt (only with CPEN391_PIO_PULSE_IRQ_EN)
//
// Register map: 0 DATA, 1 PULSE_LEN, 2 PULSE_GO (wo), 3 STATUS, 4 OUTSET (wo), 5 OUTCLR (wo),
// 6 IRQ_MASK (only with CPEN391_PIO_PULSE_IRQ_EN).
// Define CPEN391_PIO_PULSE_IRQ_EN to enable the sticky done flag, IRQ_MASK and irq.
module cpen391_pio_pulse_out #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0001,
  parameter int          CNT_W       = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [2:0] A_DATA     = 3'd0;
  localparam logic [2:0] A_LEN      = 3'd1;
  localparam logic [2:0] A_GO       = 3'd2;
  localparam logic [2:0] A_STATUS   = 3'd3;
  localparam logic [2:0] A_OUTSET   = 3'd4;
  localparam logic [2:0] A_OUTCLR   = 3'd5;
  localparam logic [2:0] A_IRQ_MASK = 3'd6;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  localparam logic [WIDTH-1:0] RST_DATA = RESET_VALUE[WIDTH-1:0];
  // STATUS places the mask at bit 8; only the bits that fit in 32 are visible.
  localparam int SW = (WIDTH > 24) ? 24 : WIDTH;

  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [WIDTH-1:0] pmask_q, pmask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:0]       state_q, state_d;
  logic             done_q;
  logic             irq_mask_q;

  logic             wr;
  logic             busy;
  logic [WIDTH-1:0] wd_w;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign busy      = (state_q == S_ACTIVE);
  assign wd_w      = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

`ifdef CPEN391_PIO_PULSE_IRQ_EN
  logic done_d, irq_mask_d;
`endif

  always_comb begin
    data_d  = data_q;
    len_d   = len_q;
    pmask_d = pmask_q;
    cnt_d   = cnt_q;
    state_d = state_q;
`ifdef CPEN391_PIO_PULSE_IRQ_EN
    done_d     = done_q;
    irq_mask_d = irq_mask_q;
`endif

    if (wr) begin
      case (address)
        A_DATA:   data_d = wd_w;
        A_LEN:    len_d  = writedata[CNT_W-1:0];
        A_OUTSET: data_d = data_q | wd_w;
        A_OUTCLR: data_d = data_q & ~wd_w;
`ifdef CPEN391_PIO_PULSE_IRQ_EN
        A_STATUS:   if (writedata[1]) done_d = 1'b0;
        A_IRQ_MASK: irq_mask_d = writedata[0];
`endif
        default: ;
      endcase
    end

    // Evaluated after the register writes so a completion beats a same-edge done clear.
    case (state_q)
      S_IDLE: begin
        if (wr && address == A_GO && len_q != '0 && wd_w != '0) begin
          state_d = S_ACTIVE;
          pmask_d = wd_w;
          cnt_d   = len_q;
        end
      end
      default: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          pmask_d = '0;
          cnt_d   = '0;
`ifdef CPEN391_PIO_PULSE_IRQ_EN
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= RST_DATA;
      len_q   <= '0;
      pmask_q <= '0;
      cnt_q   <= '0;
      state_q <= S_IDLE;
    end else begin
      data_q  <= data_d;
      len_q   <= len_d;
      pmask_q <= pmask_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

`ifdef CPEN391_PIO_PULSE_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q     <= 1'b0;
      irq_mask_q <= 1'b0;
    end else begin
      done_q     <= done_d;
      irq_mask_q <= irq_mask_d;
    end
  end
  assign irq = done_q & irq_mask_q;
`else
  assign done_q     = 1'b0;
  assign irq_mask_q = 1'b0;
  assign irq        = 1'b0;
`endif

  assign out_port = data_q ^ (busy ? pmask_q : '0);

  always_comb begin
    readdata = '0;
    case (address)
      A_DATA:   readdata[WIDTH-1:0] = data_q;
      A_LEN:    readdata[CNT_W-1:0] = len_q;
      A_STATUS: begin
        readdata[0]        = busy;
        readdata[1]        = done_q;
        readdata[SW+7:8]   = pmask_q[SW-1:0];
      end
`ifdef CPEN391_PIO_PULSE_IRQ_EN
      A_IRQ_MASK: readdata[0] = irq_mask_q;
`endif
      default: ;
    endcase
  end

endmodule

// File: doc/cpen391_pio_pulse_out.md
Name: cpen391_pio_pulse_out

Overview:
Parametrised Avalon-MM slave output PIO, WIDTH bits wide, driving board-level control lines (WiFi module reset, peripheral enables, strobes).
Adds atomic bit set/clear and a hardware-timed pulse engine, so software can assert a line for an exact cycle count without busy-waiting.
Sits on the HPS lightweight bridge beside the existing single-bit PIOs; zero-wait-state reads.

Parameters:
WIDTH, 8, number of output bits (1..32)
RESET_VALUE, 8'h01, value loaded into DATA on reset (only low WIDTH bits used)
CNT_W, 24, width of pulse length counter (1..32)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
address  input  3  word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data
readdata  output  32  read data, combinational from address
out_port  output  WIDTH  driven output lines
irq  output  1  pulse-done interrupt (see Optional Feature)

Behaviour:
- Write = chipselect & ~write_n, taking effect on the next clk edge. Reads are combinational; unmapped or write-only addresses read 0; unused upper readdata bits are 0.
- Register map:
  - 0 DATA (r/w): base value data_out[WIDTH-1:0].
  - 1 PULSE_LEN (r/w): len[CNT_W-1:0].
  - 2 PULSE_GO (write-only): writedata[WIDTH-1:0] = pulse mask.
  - 3 STATUS (r): bit0 busy; bit1 done (sticky, only with the macro); bits[WIDTH+7:8] current pulse mask.
  - 4 OUTSET (write-only): data_out <= data_out | writedata.
  - 5 OUTCLR (write-only): data_out <= data_out & ~writedata.
  - 6 IRQ_MASK (r/w, macro only): bit0.
- out_port = data_out ^ (busy ? pmask : 0). Pulsed bits invert relative to the base value for the pulse duration.
- Reset values: data_out = RESET_VALUE, len = 0, pmask = 0, busy = 0, done = 0, irq = 0, out_port = RESET_VALUE.
- Pulse FSM, states IDLE and ACTIVE:
  - IDLE -> ACTIVE on a PULSE_GO write when len != 0 and mask != 0. On that edge: pmask <= mask, cnt <= len, busy <= 1.
  - The inverted level appears on out_port the cycle after the write edge and holds for exactly len cycles.
  - In ACTIVE, cnt decrements every cycle. When cnt == 1, the next edge goes to IDLE: busy <= 0, pmask <= 0, done <= 1.
  - PULSE_GO while ACTIVE is ignored; no restart, no mask change.
  - PULSE_GO with len == 0 or mask == 0 is ignored; state stays IDLE.
  - PULSE_LEN written while ACTIVE: the register updates, the current pulse is unaffected, and the next pulse uses the new value.
- DATA, OUTSET and OUTCLR writes during ACTIVE update data_out immediately. out_port reflects the new base XOR pmask.
- Only one write is accepted per cycle, so there are no simultaneous register writes.
- Pulse end on the same edge as a DATA write: both take effect, and out_port = new data_out.
- Max len = 2^CNT_W-1 with no wrap; the counter never underflows.
- reset_n asserted mid-pulse aborts the pulse at once; out_port = RESET_VALUE asynchronously.

Optional Feature:
Macro CPEN391_PIO_PULSE_IRQ_EN.
- Defined:
  - STATUS.done sets on pulse completion and clears on a write to STATUS with writedata[1]=1.
  - If set and clear occur on the same edge, set wins.
  - IRQ_MASK register exists at address 6.
  - irq = done & irq_mask, registered-free combinational from flops.
- Not defined:
  - done reads 0.
  - IRQ_MASK is unmapped and reads 0.
  - irq is tied to 0.

Test Plan:
- Reset with RESET_VALUE=8'h01 -> out_port=8'h01, all readable registers 0 except DATA=1; release reset, DATA write 8'hA5 -> out_port=8'hA5 next cycle.
- DATA=8'hF0; OUTSET 8'h0F -> 8'hFF; OUTCLR 8'h81 -> 8'h7E; read DATA=8'h7E.
- DATA=8'h01, PULSE_LEN=5, PULSE_GO 8'h01 -> out_port=8'h00 for exactly 5 cycles starting the cycle after the write, then 8'h01; STATUS.busy=1 during and 0 after.
- During a 100-cycle pulse: PULSE_GO 8'h02 is ignored (mask stays 8'h01); OUTSET 8'h80 -> out_port bit7=1 immediately with bit0 still inverted; PULSE_LEN=0 then PULSE_GO after completion -> no pulse.
- Assert reset_n=0 at cycle 3 of a 10-cycle pulse -> out_port=RESET_VALUE immediately, busy=0; after release the pulse does not resume.
- With the macro: IRQ_MASK=1, 3-cycle pulse -> irq=1 one cycle after the pulse ends; STATUS write 32'h2 -> irq=0; mask=0 -> irq stays 0 while done=1.
